// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and frame layout.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned CHK_BYTES = 1;

  // Total bytes on the wire for a frame carrying len payload bytes.
  function automatic int unsigned frame_bytes(input logic [15:0] len);
    return LEN_BYTES + 32'(len) + CHK_BYTES;
  endfunction

endpackage

// File: rtl/byte_sum8.sv
// 8-bit modular byte accumulator with synchronous clear and enable.
module byte_sum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + din;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream loader (16-bit length, payload, checksum) driving the
// instruction memory byte write port; holds the CPU until a clean load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        load_done,
  output logic        load_error,
  output logic        cpu_hold
);

  localparam logic [31:0] LEN_LIMIT = 32'(MEM_BYTES - BASE_ADDR);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic        in_ready_q, mem_we_q, busy_q, done_q, error_q, hold_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;

  logic        xfer, armable, sum_clr, sum_en;
  logic [15:0] len_d;
  logic [7:0]  sum;

  assign xfer    = in_valid && in_ready_q;
  assign armable = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign sum_clr = start && armable;
  assign sum_en  = xfer && (state_q == S_DATA);
  assign len_d   = {len_q[15:8], in_data};

  byte_sum8 u_sum (
    .clk (clk),
    .rst (reset),
    .clr (sum_clr),
    .en  (sum_en),
    .din (in_data),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= in_data;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= len_d;
            if ({16'h0, len_d} > LEN_LIMIT) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else if (len_d == 16'h0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we_q <= 1'b1;
            addr_q   <= BASE + {16'h0, idx_q};
            wdata_q  <= in_data;
            idx_q    <= idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == sum) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          hold_q     <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame table plus corner-case sequences.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, start0 = 1'b0, start4 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        rdy0, we0, busy0, done0, err0, hold0;
  logic [31:0] addr0;
  logic [7:0]  wdata0;
  logic        rdy4, we4, busy4, done4, err4, hold4;
  logic [31:0] addr4;
  logic [7:0]  wdata4;

  instr_loader #(.MEM_BYTES(65536), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .busy(busy0), .load_done(done0), .load_error(err0), .cpu_hold(hold0));

  instr_loader #(.MEM_BYTES(65536), .BASE_ADDR(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .busy(busy4), .load_done(done4), .load_error(err4), .cpu_hold(hold4));

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int unsigned cyc = 0, wr0 = 0, wr4 = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;
  wr_t        expq[$];
  logic [7:0] mem [0:63];

  // Scoreboard: every strobe on dut0 must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (we0 === 1'b1) begin
      wr0++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want no write", addr0, wdata0);
      end else begin
        e = expq.pop_front();
        if (addr0 !== e.addr || wdata0 !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h", addr0, wdata0, e.addr, e.data);
        end
      end
      if (addr0 < 32'd64) mem[addr0[5:0]] = wdata0;
    end
    if (we4 === 1'b1) wr4++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit which);
    if (which) start4 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start4 = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit which);
    int k;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (!(which ? rdy4 : rdy0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] b, input int unsigned idx);
    wr_t w;
    w.addr = 32'(idx);
    w.data = b;
    expq.push_back(w);
    send_byte(b, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  by [10];
    bit          gap;
    bit          done;
    bit          err;
    int unsigned nwr;
  } vec_t;
  vec_t vecs [5];

  initial begin
    logic [15:0] len;
    int unsigned n, t0, w0;
    wr_t w;

    vecs[0] = '{'{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 4};
    vecs[1] = '{'{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b0, 4};
    vecs[2] = '{'{8'h00, 8'h02, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{'{8'h00, 8'h03, 8'hFF, 8'h01, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 0};

    // Reset values, held in reset and just after release.
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", {31'h0, rdy0}, 32'h0);
    chk("rst_mem_we", {31'h0, we0}, 32'h0);
    chk("rst_mem_addr", addr0, 32'h0);
    chk("rst_mem_wdata", {24'h0, wdata0}, 32'h0);
    chk("rst_flags", {28'h0, busy0, done0, err0, hold0}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_flags", {27'h0, rdy0, busy0, done0, err0, hold0}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      len = {vecs[i].by[0], vecs[i].by[1]};
      n   = frame_bytes(len);
      w0  = wr0;
      pulse_start(1'b0);
      t0  = cyc;
      for (int j = 0; j < int'(n); j++) begin
        if (j >= int'(LEN_BYTES) && j < int'(LEN_BYTES) + int'(len)) begin
          w.addr = 32'(j - int'(LEN_BYTES));
          w.data = vecs[i].by[j];
          expq.push_back(w);
        end
        send_byte(vecs[i].by[j], vecs[i].gap, 1'b0);
      end
      if (!vecs[i].gap) chk("stream_cycles", cyc - t0, n);
      chk("load_done", {31'h0, done0}, {31'h0, vecs[i].done});
      chk("load_error", {31'h0, err0}, {31'h0, vecs[i].err});
      chk("cpu_hold", {31'h0, hold0}, {31'h0, !vecs[i].done});
      chk("end_ready_busy", {30'h0, rdy0, busy0}, 32'h0);
      @(negedge clk);
      chk("write_count", wr0 - w0, vecs[i].nwr);
      chk("pending_writes", expq.size(), 32'h0);
      if (i == 0) chk("instr_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h20080005);
    end

    // Oversize length on the BASE_ADDR=4 instance: reject after the second byte.
    w0 = wr4;
    pulse_start(1'b1);
    send_byte(8'hFF, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b1);
    chk("oversize_flags", {27'h0, rdy4, busy4, done4, err4, hold4}, 32'h3);
    @(negedge clk);
    chk("oversize_no_write", wr4 - w0, 32'h0);

    // Restart from DONE after a zero-length load.
    pulse_start(1'b0);
    chk("restart_flags", {28'h0, busy0, done0, err0, hold0}, 32'h9);

    // Reset during the third payload byte of an 8-byte frame.
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    send_payload(8'h11, 0);
    send_payload(8'h22, 1);
    in_data  = 8'h33;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !rdy0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_we_ready", {30'h0, we0, rdy0}, 32'h0);
    chk("midrst_flags", {28'h0, busy0, done0, err0, hold0}, 32'h1);
    chk("midrst_addr_data", addr0 | {24'h0, wdata0}, 32'h0);
    @(negedge clk);
    chk("midrst_mem_kept", {mem[0], mem[1], mem[2]}, 32'h112202);
    chk("midrst_pending", expq.size(), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) send_payload(8'(j + 1), 32'(j));
    send_byte(8'h24, 1'b0, 1'b0);
    chk("reload_flags", {28'h0, busy0, done0, err0, hold0}, 32'h4);
    @(negedge clk);
    chk("reload_pending", expq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that fills the byte-addressed instruction memory before the CPU runs. It accepts a framed stream (16-bit length, payload, checksum) over a valid/ready byte interface and issues one byte write per payload byte, so big-endian instruction layout is preserved as sent. It sits between the host/debug link and the instruction memory write port, and holds the pipeline in stall until a load completes cleanly.

## Interface
- MEM_BYTES, 65536: instruction memory size in bytes.
- BASE_ADDR, 0: byte address of the first payload byte.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; arms a new load from IDLE, DONE or ERROR
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  byte write strobe to instruction memory
- mem_addr  output  32  byte write address
- mem_wdata  output  8  byte write data
- busy  output  1  load in progress
- load_done  output  1  frame loaded with good checksum; sticky
- load_error  output  1  length or checksum error; sticky
- cpu_hold  output  1  stall request to the CPU

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_valid may drop or wait freely.
- IDLE/DONE/ERROR + start: clear load_done, load_error, byte index, and sum; go to LEN_HI. start in any other state is ignored.
- LEN_HI: accepted byte -> len[15:8]. LEN_LO: accepted byte -> len[7:0], then:
  - len > MEM_BYTES - BASE_ADDR -> ERROR.
  - len == 0 -> CHECK.
  - else -> DATA.
- DATA: each accepted byte writes to BASE_ADDR + index, then index += 1 and sum = (sum + byte) mod 256. After byte len-1 -> CHECK.
- CHECK: accepted byte == sum -> DONE, load_done = 1. Otherwise -> ERROR, load_error = 1.
- DONE: cpu_hold = 0. ERROR: cpu_hold stays 1.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA, CHECK.
- busy = 1 in the same states.
- Index is 16 bits and cannot wrap, because len is bounded by the length check.
- mem_addr = BASE_ADDR + index, zero-extended to 32 bits.

## Timing
- Reset values:
  - State IDLE.
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, load_done = 0, load_error = 0.
  - cpu_hold = 1.
- All outputs are registered.
- Write latency: for a DATA byte accepted at edge N, mem_we is high for exactly the cycle after edge N. mem_addr and mem_wdata are valid in that cycle.
  - Back-to-back accepts produce back-to-back write cycles.
  - mem_addr and mem_wdata hold their last values when mem_we = 0.
- in_ready updates on the edge that changes state. After the byte that completes DATA, CHECK accepts from the next cycle with no bubble.
- load_done/load_error and cpu_hold change on the edge after the CHECK byte or the rejecting length byte.
- start and a transfer on the same edge while in a transfer state: the transfer proceeds and start is ignored.
- Reset mid-load:
  - Immediate return to reset values, with cpu_hold = 1.
  - A write strobe in flight is dropped.
  - Memory contents already written are left as they are.

## Structure
- Shared header instr_loader_defs.vh holds:
  - state encodings (3-bit localparams);
  - the frame layout constants LEN_BYTES = 2 and CHK_BYTES = 1.
- One sub-module is natural: byte_sum8, an 8-bit modular accumulator with clear and enable ports, reused by any future checksum-bearing links.
- The memory write port is external. This block only drives it.

## Test plan
- Frame 00 04 20 08 00 05 2D, with in_valid held high:
  - four mem_we pulses to addresses 0..3 with data 20, 08, 00, 05;
  - load_done = 1, cpu_hold falls; a read of instruction word 0 returns 32'h20080005.
- Same frame with in_valid toggling every other cycle: identical writes and final flags, and one mem_we pulse per accepted byte.
- Bad checksum, 00 02 AA 55 00 (expected FF):
  - two writes occur;
  - load_error = 1, load_done = 0, cpu_hold stays 1, in_ready = 0.
- Oversize length FF FF with BASE_ADDR = 4: ERROR right after the second byte, and no mem_we at all.
- Zero length, 00 00 00: DONE with no writes. A start pulse issued afterwards clears load_done and busy returns to 1.
- Assert reset during the 3rd payload byte of an 8-byte frame:
  - all outputs return to reset values immediately, cpu_hold = 1;
  - a following start plus a full good frame completes with load_done = 1.
